forward_hist: RTL and testbench
===============================

# forward_hist

Parametrised register-forwarding unit for the pipelined core, generalising the single-operand, one-deep forwarding path. It serves NUM_RD read operands at decode/execute and bypasses results from the current writeback bus plus a DEPTH-entry history of retired writes. Write-valid qualification, reset, a configurable zero register and a load-use stall request are included. It sits between the register-file read outputs and the ALU operand muxes.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_W, 5, register address width
- NUM_RD, 2, number of read operands served
- DEPTH, 2, history entries kept after the writeback cycle (≥1)
- ZERO_REG, 1, 1: register 0 reads as zero and never forwards

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_addr  in  NUM_RD*REG_W  operand addresses, port p at [p*REG_W +: REG_W]
- rf_data  in  NUM_RD*DATA_W  register-file read data per port
- wb_valid  in  1  writeback bus carries a real write this cycle
- wb_addr  in  REG_W  writeback destination
- wb_data  in  DATA_W  writeback value
- ex_load  in  1  instruction in execute is a load
- ex_addr  in  REG_W  destination of that load
- fwd_data  out  NUM_RD*DATA_W  resolved operand per port
- fwd_hit  out  NUM_RD  port p was satisfied by forwarding
- stall_req  out  1  load-use hazard, decode must stall one cycle

## Operation
- History: DEPTH entries {v, addr, data}; entry 0 youngest.
- Each cycle, not in reset: entry 0 ← {wb_valid & ~(ZERO_REG & wb_addr==0), wb_addr, wb_data}; entry i ← entry i-1; entry DEPTH-1 discarded.
- rst=1: every entry v←0; addr/data don't-care. Shift happens in no other form during reset.
- Per port p, combinational priority, first match wins:
  1. ZERO_REG & rd_addr==0 → data 0, hit 0
  2. wb_valid & wb_addr==rd_addr → wb_data, hit 1
  3. lowest i with entry i v=1 and addr==rd_addr → entry i data, hit 1
  4. otherwise → rf_data, hit 0
- Ports resolve independently; same address on two ports gives identical outputs.
- Invalid entries (v=0) never match even if addr equal.
- stall_req = ex_load & (ex_addr!=0 | ~ZERO_REG) & any port p with rd_addr==ex_addr. Combinational; the unit does not itself hold state on stall.
- ZERO_REG=0: register 0 is an ordinary register, forwards normally.

## Timing
- fwd_data, fwd_hit, stall_req: zero-cycle combinational from inputs and history.
- A write on the bus in cycle t is forwardable in cycle t (bus), t+1 … t+DEPTH (history), then only via rf_data.
- After rst deasserts: history empty, all hits 0 until a valid write, fwd_data = rf_data (or 0 for reg 0).
- Reset mid-operation: history cleared on that edge; bus forwarding (rule 2) stays combinationally active during reset.
- Back-to-back writes to same register: youngest wins (bus over entry 0 over entry 1 …).

## Structure
- Shared package: default widths DATA_W/REG_W and the zero-register index constant, reused by register file and hazard logic.
- One sub-module natural: forward_mux — single-port priority resolver (rules 1–4) instantiated NUM_RD times via generate; history shift register and stall compare stay in the top.

## Test plan
- Reset: rst=1 two cycles, then rd_addr=3, rf_data=0x11 → fwd_data=0x11, hit=0, stall_req=0.
- Bus and history: write r5=0xAAAA at t; read r5 at t, t+1, t+2 (DEPTH=2) → 0xAAAA, hit=1; at t+3 → rf_data, hit=0.
- Priority: write r7=1 at t, r7=2 at t+1; read r7 at t+1 → 2; at t+2 → 2 (entry 0, not entry 1).
- Zero register: wb_valid=1, wb_addr=0, wb_data=0xFFFF; read r0 on both ports at t and t+1 → 0, hit=0; with ZERO_REG=0 → 0xFFFF, hit=1.
- wb_valid=0 with wb_addr=9, wb_data=0x5; read r9 → rf_data, hit=0, also next cycle.
- Load-use: ex_load=1, ex_addr=4, port 1 reads r4 → stall_req=1; ex_addr=0 (ZERO_REG=1) → stall_req=0; rst pulse mid-sequence → history hits drop to 0 next cycle.

Source files
------------

// File: rtl/forward_hist_pkg.sv
// forward_hist_pkg: shared widths and zero-register index for the forwarding,
// register-file and hazard logic.
package forward_hist_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_W_DEF  = 5;
   localparam int ZERO_IDX   = 0;

endpackage : forward_hist_pkg

// File: rtl/forward_hist_mux.sv
// forward_hist_mux: single read-port priority resolver.
// Order: zero register, writeback bus, youngest valid history entry, register file.
module forward_hist_mux
   import forward_hist_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int REG_W    = REG_W_DEF,
   parameter int DEPTH    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic [REG_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]       rf_data,
   input  logic                    wb_valid,
   input  logic [REG_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]       wb_data,
   input  logic [DEPTH-1:0]        hist_v,
   input  logic [DEPTH*REG_W-1:0]  hist_addr,
   input  logic [DEPTH*DATA_W-1:0] hist_data,
   output logic [DATA_W-1:0]       fwd_data,
   output logic                    fwd_hit
);

   logic              hist_found_s;
   logic [DATA_W-1:0] hist_sel_s;
   logic              is_zero_s;

   // Find the youngest valid history entry matching the read address.
   always_comb begin
      hist_found_s = 1'b0;
      hist_sel_s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!hist_found_s && hist_v[i] &&
             (hist_addr[i*REG_W +: REG_W] == rd_addr)) begin
            hist_found_s = 1'b1;
            hist_sel_s   = hist_data[i*DATA_W +: DATA_W];
         end else begin
            hist_found_s = hist_found_s;
         end
      end
   end

   // Apply the full priority chain; the zero register shadows everything.
   always_comb begin
      is_zero_s = (ZERO_REG != 0) && (rd_addr == REG_W'(ZERO_IDX));
      fwd_data  = rf_data;
      fwd_hit   = 1'b0;
      if (is_zero_s) begin
         fwd_data = '0;
         fwd_hit  = 1'b0;
      end else if (wb_valid && (wb_addr == rd_addr)) begin
         fwd_data = wb_data;
         fwd_hit  = 1'b1;
      end else if (hist_found_s) begin
         fwd_data = hist_sel_s;
         fwd_hit  = 1'b1;
      end else begin
         fwd_data = rf_data;
         fwd_hit  = 1'b0;
      end
   end

endmodule : forward_hist_mux

// File: rtl/forward_hist.sv
// forward_hist: multi-port register forwarding from the writeback bus plus a
// DEPTH-entry history of retired writes, with load-use stall detection.
module forward_hist
   import forward_hist_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int REG_W    = REG_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int DEPTH    = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*REG_W-1:0]  rd_addr,
   input  logic [NUM_RD*DATA_W-1:0] rf_data,
   input  logic                     wb_valid,
   input  logic [REG_W-1:0]         wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     ex_load,
   input  logic [REG_W-1:0]         ex_addr,
   output logic [NUM_RD*DATA_W-1:0] fwd_data,
   output logic [NUM_RD-1:0]        fwd_hit,
   output logic                     stall_req
);

   logic [DEPTH-1:0]        hist_v_q,    hist_v_d;
   logic [DEPTH*REG_W-1:0]  hist_addr_q, hist_addr_d;
   logic [DEPTH*DATA_W-1:0] hist_data_q, hist_data_d;
   logic                    wb_is_zero_s;
   logic                    ld_match_s;
   logic                    ex_is_zero_s;

   // Next history: bus write enters entry 0, older entries shift down.
   always_comb begin
      wb_is_zero_s = (ZERO_REG != 0) && (wb_addr == REG_W'(ZERO_IDX));
      hist_v_d     = hist_v_q;
      hist_addr_d  = hist_addr_q;
      hist_data_d  = hist_data_q;
      hist_v_d[0]                = wb_valid && !wb_is_zero_s;
      hist_addr_d[REG_W-1:0]     = wb_addr;
      hist_data_d[DATA_W-1:0]    = wb_data;
      for (int i = 1; i < DEPTH; i++) begin
         hist_v_d[i]                  = hist_v_q[i-1];
         hist_addr_d[i*REG_W +: REG_W]   = hist_addr_q[(i-1)*REG_W +: REG_W];
         hist_data_d[i*DATA_W +: DATA_W] = hist_data_q[(i-1)*DATA_W +: DATA_W];
      end
   end

   // History registers; reset only invalidates, address/data are don't-care.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_v_q    <= '0;
         hist_addr_q <= hist_addr_q;
         hist_data_q <= hist_data_q;
      end else begin
         hist_v_q    <= hist_v_d;
         hist_addr_q <= hist_addr_d;
         hist_data_q <= hist_data_d;
      end
   end

   // One priority resolver per read port.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      forward_hist_mux #(
         .DATA_W   (DATA_W),
         .REG_W    (REG_W),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG)
      ) u_mux (
         .rd_addr   (rd_addr[p*REG_W +: REG_W]),
         .rf_data   (rf_data[p*DATA_W +: DATA_W]),
         .wb_valid  (wb_valid),
         .wb_addr   (wb_addr),
         .wb_data   (wb_data),
         .hist_v    (hist_v_q),
         .hist_addr (hist_addr_q),
         .hist_data (hist_data_q),
         .fwd_data  (fwd_data[p*DATA_W +: DATA_W]),
         .fwd_hit   (fwd_hit[p])
      );
   end

   // Load-use hazard: any port reading the destination of a load in execute.
   always_comb begin
      ld_match_s   = 1'b0;
      ex_is_zero_s = (ZERO_REG != 0) && (ex_addr == REG_W'(ZERO_IDX));
      for (int p = 0; p < NUM_RD; p++) begin
         if (rd_addr[p*REG_W +: REG_W] == ex_addr) begin
            ld_match_s = 1'b1;
         end else begin
            ld_match_s = ld_match_s;
         end
      end
      stall_req = ex_load && !ex_is_zero_s && ld_match_s;
   end

endmodule : forward_hist

// File: tb/tb_forward_hist.sv
// tb_forward_hist: directed vectors for forward_hist; one instance with the
// zero register enabled and one with it disabled, driven from shared inputs.
module tb_forward_hist;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk;
   logic          rst;
   logic [2*RW-1:0] rd_addr;
   logic [2*DW-1:0] rf_data;
   logic          wb_valid;
   logic [RW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          ex_load;
   logic [RW-1:0] ex_addr;
   logic [2*DW-1:0] fwd_data, fwd_data_nz;
   logic [1:0]    fwd_hit, fwd_hit_nz;
   logic          stall_req, stall_req_nz;

   int n_cmp;
   int n_bad;

   forward_hist #(.DATA_W(DW), .REG_W(RW), .NUM_RD(2), .DEPTH(2), .ZERO_REG(1)) u_dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rf_data(rf_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_load(ex_load), .ex_addr(ex_addr),
      .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall_req(stall_req)
   );

   forward_hist #(.DATA_W(DW), .REG_W(RW), .NUM_RD(2), .DEPTH(2), .ZERO_REG(0)) u_dut_nz (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rf_data(rf_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .ex_load(ex_load), .ex_addr(ex_addr),
      .fwd_data(fwd_data_nz), .fwd_hit(fwd_hit_nz), .stall_req(stall_req_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge so new inputs land mid-cycle.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [RW-1:0] a0, input logic [DW-1:0] d0,
                         input logic [RW-1:0] a1, input logic [DW-1:0] d1);
      rd_addr = {a1, a0};
      rf_data = {d1, d0};
   endtask

   task automatic set_wb(input logic v, input logic [RW-1:0] a, input logic [DW-1:0] d);
      wb_valid = v;
      wb_addr  = a;
      wb_data  = d;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      ex_load = 1'b0;
      ex_addr = 5'd0;
      set_wb(1'b0, 5'd0, 32'h0);
      set_rd(5'd3, 32'h11, 5'd6, 32'h22);

      // Reset for two cycles, then an empty history.
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      check_val("rst_data0", fwd_data[31:0], 32'h11);
      check_val("rst_data1", fwd_data[63:32], 32'h22);
      check_val("rst_hit", {30'd0, fwd_hit}, 32'h0);
      check_val("rst_stall", {31'd0, stall_req}, 32'h0);

      // Bus then history forwarding of r5, both ports same address.
      next_cycle();
      set_wb(1'b1, 5'd5, 32'hAAAA);
      set_rd(5'd5, 32'h1234, 5'd5, 32'h1234);
      #1;
      check_val("bus_data0", fwd_data[31:0], 32'hAAAA);
      check_val("bus_data1", fwd_data[63:32], 32'hAAAA);
      check_val("bus_hit", {30'd0, fwd_hit}, 32'h3);
      next_cycle();
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      check_val("h0_data", fwd_data[31:0], 32'hAAAA);
      check_val("h0_hit", {30'd0, fwd_hit}, 32'h3);
      next_cycle();
      #1;
      check_val("h1_data", fwd_data[31:0], 32'hAAAA);
      check_val("h1_hit", {31'd0, fwd_hit[0]}, 32'h1);
      next_cycle();
      #1;
      check_val("aged_data", fwd_data[31:0], 32'h1234);
      check_val("aged_hit", {30'd0, fwd_hit}, 32'h0);

      // Back-to-back writes to r7: youngest wins.
      next_cycle();
      set_wb(1'b1, 5'd7, 32'h1);
      set_rd(5'd7, 32'h70, 5'd8, 32'h80);
      #1;
      check_val("b2b_t0", fwd_data[31:0], 32'h1);
      next_cycle();
      set_wb(1'b1, 5'd7, 32'h2);
      #1;
      check_val("b2b_bus_over_h0", fwd_data[31:0], 32'h2);
      next_cycle();
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      check_val("b2b_h0_over_h1", fwd_data[31:0], 32'h2);
      next_cycle();
      #1;
      check_val("b2b_h1", fwd_data[31:0], 32'h2);
      check_val("b2b_port1_rf", fwd_data[63:32], 32'h80);

      // Writes to r0: masked with the zero register, ordinary without it.
      next_cycle();
      set_wb(1'b1, 5'd0, 32'hFFFF);
      set_rd(5'd0, 32'h33, 5'd0, 32'h44);
      #1;
      check_val("z_bus_data", fwd_data, 32'h0);
      check_val("z_bus_data1", fwd_data[63:32], 32'h0);
      check_val("z_bus_hit", {30'd0, fwd_hit}, 32'h0);
      check_val("nz_bus_data1", fwd_data_nz[63:32], 32'hFFFF);
      check_val("nz_bus_hit", {30'd0, fwd_hit_nz}, 32'h3);
      next_cycle();
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      check_val("z_h0_data", fwd_data[31:0], 32'h0);
      check_val("z_h0_hit", {30'd0, fwd_hit}, 32'h0);
      check_val("nz_h0_data", fwd_data_nz[31:0], 32'hFFFF);
      check_val("nz_h0_hit", {30'd0, fwd_hit_nz}, 32'h3);

      // A non-valid bus value is never forwarded, now or later.
      next_cycle();
      set_wb(1'b0, 5'd9, 32'h5);
      set_rd(5'd9, 32'h99, 5'd10, 32'hA0);
      #1;
      check_val("inv_bus_data", fwd_data[31:0], 32'h99);
      check_val("inv_bus_hit", {30'd0, fwd_hit}, 32'h0);
      next_cycle();
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      check_val("inv_h0_data", fwd_data[31:0], 32'h99);
      check_val("inv_h0_hit", {30'd0, fwd_hit}, 32'h0);

      // Load-use stall.
      ex_load = 1'b1;
      ex_addr = 5'd4;
      set_rd(5'd2, 32'h20, 5'd4, 32'h40);
      #1;
      check_val("lu_stall", {31'd0, stall_req}, 32'h1);
      ex_addr = 5'd0;
      set_rd(5'd0, 32'h20, 5'd4, 32'h40);
      #1;
      check_val("lu_r0_stall", {31'd0, stall_req}, 32'h0);
      check_val("lu_r0_stall_nz", {31'd0, stall_req_nz}, 32'h1);
      ex_addr = 5'd6;
      #1;
      check_val("lu_nomatch", {31'd0, stall_req}, 32'h0);
      ex_load = 1'b0;
      ex_addr = 5'd4;
      #1;
      check_val("lu_noload", {31'd0, stall_req}, 32'h0);

      // Reset mid-operation clears history; bus forwarding stays live.
      next_cycle();
      set_wb(1'b1, 5'd12, 32'hBEEF);
      set_rd(5'd12, 32'hC0, 5'd13, 32'hD0);
      #1;
      check_val("mr_bus", fwd_data[31:0], 32'hBEEF);
      next_cycle();
      rst = 1'b1;
      set_wb(1'b1, 5'd13, 32'h77);
      #1;
      check_val("mr_h0_before", fwd_data[31:0], 32'hBEEF);
      check_val("mr_bus_in_rst", fwd_data[63:32], 32'h77);
      check_val("mr_hit_in_rst", {30'd0, fwd_hit}, 32'h3);
      next_cycle();
      rst = 1'b0;
      set_wb(1'b0, 5'd0, 32'h0);
      #1;
      check_val("mr_data0_after", fwd_data[31:0], 32'hC0);
      check_val("mr_data1_after", fwd_data[63:32], 32'hD0);
      check_val("mr_hit_after", {30'd0, fwd_hit}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_forward_hist
